// File: rtl/nn_pkg.sv
// Shared definitions for the fully-connected layer slice.
// Holds the layer geometry and the sequencer state encoding.
`timescale 1ns/1ps
package nn_pkg;

  localparam int unsigned N_PIX   = 784;
  localparam int unsigned N_NEU   = 10;
  localparam int unsigned IMG_DIM = 28;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    BIAS,
    VALID
  } fc_state_t;

endpackage

// File: rtl/fc_layer_seq_if.sv
// Control/handshake bundle between the fc_layer_seq sequencer and its
// surroundings (host control, pixel/weight memories, MAC datapath, consumer).
//   master : the sequencer (drives busy, rd_en, rd_addr, acc_clr, acc_en,
//            bias_en, out_valid; receives start, abort, stall, out_ready)
//   slave  : everything around it
`timescale 1ns/1ps
interface fc_layer_seq_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic              abort;
  logic              stall;
  logic              busy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              acc_clr;
  logic              acc_en;
  logic              bias_en;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  start, abort, stall, out_ready,
    output busy, rd_en, rd_addr, acc_clr, acc_en, bias_en, out_valid
  );

  modport slave (
    output start, abort, stall, out_ready,
    input  busy, rd_en, rd_addr, acc_clr, acc_en, bias_en, out_valid
  );
endinterface

// File: rtl/fc_layer_seq_lat_pipe.sv
// lat_pipe: DEPTH-deep 1-bit shift register matching memory read latency.
//   clk, reset (async, active-high), flush (sync clear), din -> dout after
//   DEPTH cycles; empty_next reports that the register will hold no ones
//   after the coming edge.
`timescale 1ns/1ps
module lat_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic din,
  output logic dout,
  output logic empty_next
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  always_comb begin
    pipe_d = '0;
    if (!flush) begin
      pipe_d[0] = din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pipe_q <= '0;
    else       pipe_q <= pipe_d;
  end

  assign dout       = pipe_q[DEPTH-1];
  assign empty_next = (pipe_d == '0);

endmodule

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequencer for the 784-input x 10-neuron MAC datapath.
//   clk, reset (async, active-high)
//   bus (master): start/abort/stall/out_ready in; busy, rd_en, rd_addr,
//   acc_clr, acc_en, bias_en, out_valid out.
// Walks the pixel/weight index once per inference, delays rd_en by RD_LAT
// to form acc_en, then strobes bias_en and holds out_valid until accepted.
`timescale 1ns/1ps
module fc_layer_seq
  import nn_pkg::*;
#(
  parameter int unsigned N_IN   = N_PIX,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  fc_layer_seq_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);

  fc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_c;
  logic              flush;
  logic              pipe_empty_next;
  logic              acc_en_c;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_en_c = (state_q == RUN) && !bus.stall;
    flush   = bus.abort && (state_q != IDLE);

    unique case (state_q)
      IDLE:  if (bus.start) state_d = CLEAR;
      CLEAR: state_d = RUN;
      RUN: begin
        if (rd_en_c) begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      // Leave as soon as the edge that emits the last acc_en has passed.
      DRAIN: if (pipe_empty_next) state_d = BIAS;
      BIAS:  state_d = VALID;
      VALID: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      addr_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  lat_pipe #(.DEPTH(RD_LAT)) u_lat_pipe (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .din        (rd_en_c),
    .dout       (acc_en_c),
    .empty_next (pipe_empty_next)
  );

  assign bus.busy      = (state_q != IDLE);
  assign bus.rd_en     = rd_en_c;
  assign bus.rd_addr   = addr_q;
  assign bus.acc_clr   = (state_q == CLEAR);
  assign bus.acc_en    = acc_en_c;
  assign bus.bias_en   = (state_q == BIAS);
  assign bus.out_valid = (state_q == VALID);

endmodule

// File: tb/tb_fc_layer_seq.sv
// Self-checking bench for fc_layer_seq (RD_LAT=1 main instance, RD_LAT=3
// companion instance sharing the same control inputs).
`timescale 1ns/1ps
module tb_fc_layer_seq;
  localparam int N = 784;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fc_layer_seq_if #(.ADDR_W(10)) b1 ();
  fc_layer_seq_if #(.ADDR_W(10)) b3 ();

  fc_layer_seq #(.N_IN(N), .ADDR_W(10), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.master));
  fc_layer_seq #(.N_IN(N), .ADDR_W(10), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .bus(b3.master));

  assign b3.start     = b1.start;
  assign b3.abort     = b1.abort;
  assign b3.stall     = b1.stall;
  assign b3.out_ready = b1.out_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  bit mon   = 1'b0;

  int n_clr, clr_k, n_rd, rd_first, rd_last, addr_err, addr_hi, exp_addr;
  int n_acc, acc_first, acc_last, n_bias, bias_k, n_valid, valid_first;
  int busy_low_k, overlap, hold_ok, post_abort, abort_k;
  int n_acc3, acc_first3, acc_last3, valid_first3;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    n_clr = 0; clr_k = -1; n_rd = 0; rd_first = -1; rd_last = -1;
    addr_err = 0; addr_hi = 0; exp_addr = 0;
    n_acc = 0; acc_first = -1; acc_last = -1; n_bias = 0; bias_k = -1;
    n_valid = 0; valid_first = -1; busy_low_k = -1; overlap = 0;
    hold_ok = 0; post_abort = 0; abort_k = 1 << 30;
    n_acc3 = 0; acc_first3 = -1; acc_last3 = -1; valid_first3 = -1;
  endtask

  always @(negedge clk) begin : monitor
    int k;
    if (mon) begin
      k = cyc - t0 + 1;
      if (b1.acc_clr) begin n_clr++; clr_k = k; end
      if (b1.rd_en) begin
        n_rd++;
        if (rd_first < 0) rd_first = k;
        rd_last = k;
        if (int'(b1.rd_addr) != exp_addr) addr_err++;
        exp_addr++;
      end
      if (int'(b1.rd_addr) >= N) addr_hi++;
      if (b1.acc_en) begin
        n_acc++;
        if (acc_first < 0) acc_first = k;
        acc_last = k;
      end
      if (b1.bias_en) begin n_bias++; bias_k = k; end
      if (b1.out_valid) begin
        n_valid++;
        if (valid_first < 0) valid_first = k;
      end
      if (!b1.busy && busy_low_k < 0 && k > 1) busy_low_k = k;
      if (int'(b1.acc_clr) + int'(b1.acc_en) + int'(b1.bias_en) > 1) overlap++;
      if (b1.stall && k >= 100 && k <= 109 && b1.rd_addr == 10'd98 && !b1.rd_en)
        hold_ok++;
      if (k > abort_k && (b1.rd_en || b1.acc_en || b1.bias_en || b1.out_valid))
        post_abort++;
      if (b3.acc_en) begin
        n_acc3++;
        if (acc_first3 < 0) acc_first3 = k;
        acc_last3 = k;
      end
      if (b3.out_valid && valid_first3 < 0) valid_first3 = k;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // start is sampled at edge 0; the interval ending at edge k is cycle k
  task automatic launch();
    clr_stats();
    b1.start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    b1.start = 1'b0;
    mon = 1'b1;
  endtask

  // return inside cycle k (just after edge k-1)
  task automatic wait_k(input int k);
    int guard = 0;
    while (cyc - t0 < k - 1 && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 5000) chk("wait_k", cyc - t0, k - 1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((b1.busy || b3.busy) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", int'(b1.busy || b3.busy), 0);
    step(2);
    mon = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    b1.start = 1'b0; b1.abort = 1'b0; b1.stall = 1'b0; b1.out_ready = 1'b1;
    reset = 1'b1;
    step(3);
    chk("rst_busy",    int'(b1.busy), 0);
    chk("rst_rd_en",   int'(b1.rd_en), 0);
    chk("rst_rd_addr", int'(b1.rd_addr), 0);
    chk("rst_acc_clr", int'(b1.acc_clr), 0);
    chk("rst_acc_en",  int'(b1.acc_en), 0);
    chk("rst_bias_en", int'(b1.bias_en), 0);
    chk("rst_valid",   int'(b1.out_valid), 0);
    reset = 1'b0;
    step(2);

    // nominal run, both latencies
    launch();
    wait_idle(3000);
    chk("s1_clr_k",     clr_k, 1);
    chk("s1_n_clr",     n_clr, 1);
    chk("s1_rd_first",  rd_first, 2);
    chk("s1_rd_last",   rd_last, 785);
    chk("s1_n_rd",      n_rd, 784);
    chk("s1_addr_err",  addr_err, 0);
    chk("s1_addr_hi",   addr_hi, 0);
    chk("s1_acc_first", acc_first, 3);
    chk("s1_acc_last",  acc_last, 786);
    chk("s1_n_acc",     n_acc, 784);
    chk("s1_bias_k",    bias_k, 787);
    chk("s1_n_bias",    n_bias, 1);
    chk("s1_valid_k",   valid_first, 788);
    chk("s1_n_valid",   n_valid, 1);
    chk("s1_busy_low",  busy_low_k, 789);
    chk("s1_overlap",   overlap, 0);
    chk("l3_acc_first", acc_first3, 5);
    chk("l3_acc_last",  acc_last3, 788);
    chk("l3_n_acc",     n_acc3, 784);
    chk("l3_valid_k",   valid_first3, 790);

    // stall cycles 100..109
    launch();
    wait_k(100); b1.stall = 1'b1;
    wait_k(110); b1.stall = 1'b0;
    wait_idle(3000);
    chk("s2_hold_ok",   hold_ok, 10);
    chk("s2_n_rd",      n_rd, 784);
    chk("s2_n_acc",     n_acc, 784);
    chk("s2_addr_err",  addr_err, 0);
    chk("s2_rd_last",   rd_last, 795);
    chk("s2_valid_k",   valid_first, 798);

    // back-pressure: out_ready low until cycle 808, stray starts ignored
    b1.out_ready = 1'b0;
    launch();
    wait_k(790); b1.start = 1'b1;
    wait_k(791); b1.start = 1'b0;
    wait_k(808); b1.out_ready = 1'b1; b1.start = 1'b1;
    wait_k(809); b1.start = 1'b0;
    chk("s3_busy_809",  int'(b1.busy), 0);
    wait_idle(100);
    chk("s3_valid_k",   valid_first, 788);
    chk("s3_n_valid",   n_valid, 21);
    chk("s3_busy_low",  busy_low_k, 809);
    chk("s3_n_rd",      n_rd, 784);
    chk("s3_n_acc",     n_acc, 784);
    chk("s3_n_bias",    n_bias, 1);
    chk("s3_n_clr",     n_clr, 1);
    step(3);
    chk("s3_no_queue",  int'(b1.busy), 0);

    // abort at cycle 400, then a clean run
    launch();
    abort_k = 400;
    wait_k(400); b1.abort = 1'b1;
    wait_k(401); b1.abort = 1'b0;
    chk("s4_busy_401",  int'(b1.busy), 0);
    step(10);
    mon = 1'b0;
    chk("s4_post",      post_abort, 0);
    chk("s4_n_rd",      n_rd, 399);
    chk("s4_n_acc",     n_acc, 398);
    chk("s4_n_bias",    n_bias, 0);
    chk("s4_n_valid",   n_valid, 0);
    chk("s4_busy_low",  busy_low_k, 401);
    launch();
    wait_idle(3000);
    chk("s4b_rd_first", rd_first, 2);
    chk("s4b_n_rd",     n_rd, 784);
    chk("s4b_addr_err", addr_err, 0);
    chk("s4b_valid_k",  valid_first, 788);

    // asynchronous reset mid-RUN
    launch();
    wait_k(300);
    #2 reset = 1'b1;
    #1;
    chk("s5_busy",      int'(b1.busy), 0);
    chk("s5_rd_en",     int'(b1.rd_en), 0);
    chk("s5_rd_addr",   int'(b1.rd_addr), 0);
    chk("s5_acc_en",    int'(b1.acc_en), 0);
    chk("s5_acc_en3",   int'(b3.acc_en), 0);
    mon = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    step(2);
    launch();
    wait_idle(3000);
    chk("s5b_clr_k",    clr_k, 1);
    chk("s5b_rd_first", rd_first, 2);
    chk("s5b_rd_last",  rd_last, 785);
    chk("s5b_n_rd",     n_rd, 784);
    chk("s5b_acc_last", acc_last, 786);
    chk("s5b_bias_k",   bias_k, 787);
    chk("s5b_valid_k",  valid_first, 788);
    chk("s5b_busy_low", busy_low_k, 789);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
